seg7_scan_driver: RTL and testbench

Multi-digit, time-multiplexed 7-segment display driver and the parametrised successor of the team's single-digit BCD decoder. It captures a binary value and converts it sequentially to BCD with a double-dabble engine, or takes it directly as hex nibbles. It then scans DIGITS common-anode/cathode positions with leading-zero blanking and overflow indication. It sits between datapath result registers and the board's segment/digit-select pins.

---
 rtl/seg7_scan_if.sv | 25 ++
 rtl/seg7_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Capture/status bundle between a datapath result register and seg7_scan_driver.
// load is taken only in a cycle where busy is low; a load while busy is high is dropped.
interface seg7_scan_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 16
);
    logic              load;
    logic [DATA_W-1:0] value;
    logic              hex_mode;
    logic              blank_lz;
    logic              busy;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (
        output load, value, hex_mode, blank_lz,
        input  busy, overflow, seg, an
    );

    modport slave (
        input  load, value, hex_mode, blank_lz,
        output busy, overflow, seg, an
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-position 7-segment driver: captures a value, converts it to
// BCD (double dabble) or hex nibbles, then scans it out with blanking and overflow dashes.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    seg7_scan_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int BCD_DIGITS = (DATA_W * 30103 + 99999) / 100000 + 1;
    localparam int NWIDE      = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
    localparam int REF_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W      = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t                    state;
    logic                      busy_r;
    logic [CNT_W-1:0]          cnt;
    logic [DATA_W-1:0]         bin_sr;
    logic [4*BCD_DIGITS-1:0]   bcd;
    logic                      hex_l;
    logic                      blz_l;
    logic [DIGITS-1:0][3:0]    disp_digits;
    logic                      disp_ovf;
    logic [DIGITS-1:0]         disp_mask;
    logic                      display_valid;
    logic [REF_W-1:0]          ref_cnt;
    logic [IDX_W-1:0]          scan_idx;
    logic [6:0]                seg_r;
    logic [DIGITS-1:0]         an_r;

    logic [4*BCD_DIGITS-1:0]   adj;
    logic [4*BCD_DIGITS-1:0]   bcd_shift;
    logic [DATA_W-1:0]         bin_shift;
    logic [4*NWIDE-1:0]        wide;
    logic [DIGITS-1:0][3:0]    cm_digits;
    logic                      cm_ovf;
    logic [DIGITS-1:0]         cm_mask;
    logic                      seen;
    logic                      commit;
    logic [DIGITS-1:0][3:0]    nxt_digits;
    logic                      nxt_ovf;
    logic [DIGITS-1:0]         nxt_mask;
    logic                      nxt_valid;
    logic                      ref_wrap;
    logic [IDX_W-1:0]          nxt_idx;
    logic [6:0]                nxt_seg;
    logic [DIGITS-1:0]         nxt_an;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'h0: encode = 7'h7E;
            4'h1: encode = 7'h30;
            4'h2: encode = 7'h6D;
            4'h3: encode = 7'h79;
            4'h4: encode = 7'h33;
            4'h5: encode = 7'h5B;
            4'h6: encode = 7'h5F;
            4'h7: encode = 7'h70;
            4'h8: encode = 7'h7F;
            4'h9: encode = 7'h7B;
            4'hA: encode = 7'h77;
            4'hB: encode = 7'h1F;
            4'hC: encode = 7'h4E;
            4'hD: encode = 7'h3D;
            4'hE: encode = 7'h4F;
            default: encode = 7'h47;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {bcd_shift, bin_shift} = {adj, bin_sr} << 1;
    end

    always_comb begin
        wide = '0;
        if (hex_l) wide[DATA_W-1:0] = bin_sr;
        else       wide[4*BCD_DIGITS-1:0] = bcd;
        cm_ovf = 1'b0;
        for (int i = DIGITS; i < NWIDE; i++) begin
            if (wide[4*i +: 4] != 4'd0) cm_ovf = 1'b1;
        end
        cm_digits = '0;
        for (int i = 0; i < DIGITS; i++) cm_digits[i] = wide[4*i +: 4];
        // Walk down from the top digit; everything above the first nonzero digit is blankable.
        seen    = 1'b0;
        cm_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (cm_digits[i] != 4'd0) seen = 1'b1;
            cm_mask[i] = blz_l && !cm_ovf && !seen;
        end
    end

    // seg/an are computed from post-edge state so they always match the registered scan index.
    always_comb begin
        commit     = (state == COMMIT);
        nxt_digits = commit ? cm_digits : disp_digits;
        nxt_ovf    = commit ? cm_ovf : disp_ovf;
        nxt_mask   = commit ? cm_mask : disp_mask;
        nxt_valid  = display_valid | commit;
        ref_wrap   = (ref_cnt == REF_W'(REFRESH_DIV - 1));
        nxt_idx    = scan_idx;
        if (ref_wrap) nxt_idx = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        nxt_seg = 7'h00;
        nxt_an  = '0;
        if (nxt_valid) begin
            nxt_an = DIGITS'(1) << nxt_idx;
            if (nxt_ovf)                nxt_seg = 7'h01;
            else if (!nxt_mask[nxt_idx]) nxt_seg = encode(nxt_digits[nxt_idx]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy_r        <= 1'b0;
            cnt           <= '0;
            bin_sr        <= '0;
            bcd           <= '0;
            hex_l         <= 1'b0;
            blz_l         <= 1'b0;
            disp_digits   <= '0;
            disp_ovf      <= 1'b0;
            disp_mask     <= '0;
            display_valid <= 1'b0;
            ref_cnt       <= '0;
            scan_idx      <= '0;
            seg_r         <= '0;
            an_r          <= '0;
        end else begin
            ref_cnt       <= ref_wrap ? '0 : ref_cnt + REF_W'(1);
            scan_idx      <= nxt_idx;
            disp_digits   <= nxt_digits;
            disp_ovf      <= nxt_ovf;
            disp_mask     <= nxt_mask;
            display_valid <= nxt_valid;
            seg_r         <= nxt_seg;
            an_r          <= nxt_an;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bin_sr <= bus.value;
                        hex_l  <= bus.hex_mode;
                        blz_l  <= bus.blank_lz;
                        bcd    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= bus.hex_mode ? COMMIT : CONV;
                    end
                end
                CONV: begin
                    bcd    <= bcd_shift;
                    bin_sr <= bin_shift;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.overflow = disp_ovf;
    assign bus.seg      = seg_r;
    assign bus.an       = an_r;
    assign dbg_state    = state;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, DATA_W=16, REFRESH_DIV=4; expected segment
// patterns come from a decimal/hex digit model built from segment-letter strings.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4;
    localparam int DATA_W = 16;
    localparam int RDIV   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q[$];
    logic       exp_ovf;

    seg7_scan_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

    seg7_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .REFRESH_DIV(RDIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic string glyph(input int d);
        case (d)
            0: return "ABCDEF";   1: return "BC";      2: return "ABDEG";   3: return "ABCDG";
            4: return "BCFG";     5: return "ACDFG";   6: return "ACDEFG";  7: return "ABC";
            8: return "ABCDEFG";  9: return "ABCDFG";  10: return "ABCEFG"; 11: return "CDEFG";
            12: return "ADEF";    13: return "BCDEG";  14: return "ADEFG";  default: return "AEFG";
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input string s);
        logic [6:0] b = '0;
        for (int k = 0; k < s.len(); k++) b[6 - (int'(s[k]) - 65)] = 1'b1;
        return b;
    endfunction

    // Reference: digits by plain division, overflow by magnitude, blanking above the top nonzero digit.
    function automatic void compute_expected(input int v, input bit hx, input bit blz);
        int d[DIGITS];
        int p = 1;
        int msd = 0;
        bit ovf;
        for (int i = 0; i < DIGITS; i++) begin
            if (hx) d[i] = (v >> (4 * i)) & 15;
            else begin
                d[i] = (v / p) % 10;
                p = p * 10;
            end
        end
        ovf = hx ? ((v >> (4 * DIGITS)) != 0) : (v >= p);
        for (int i = 0; i < DIGITS; i++) if (d[i] != 0) msd = i;
        exp_q.delete();
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf)                  exp_q.push_back(seg_of("G"));
            else if (blz && i > msd)  exp_q.push_back(7'h00);
            else                      exp_q.push_back(seg_of(glyph(d[i])));
        end
        exp_ovf = ovf;
    endfunction

    task automatic check_dark(input int n, input string name);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            total++;
            if (bus.seg !== 7'h00 || bus.an !== 4'h0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
                bad++;
                $display("FAIL %s cyc%0d: seg=%h an=%b busy=%b ovf=%b, required all zero",
                         name, c, bus.seg, bus.an, bus.busy, bus.overflow);
            end
        end
    endtask

    task automatic check_display(input int n, input string name);
        int prev = -1;
        int run = 0;
        bit first = 1'b1;
        int idx;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            total++;
            if ($countones(bus.an) != 1) begin
                bad++;
                $display("FAIL %s onehot: an=%b, required one-hot", name, bus.an);
                continue;
            end
            idx = $clog2(bus.an);
            total++;
            if (bus.seg !== exp_q[idx]) begin
                bad++;
                $display("FAIL %s digit%0d: seg=%h, required %h", name, idx, bus.seg, exp_q[idx]);
            end
            if (idx == prev) run++;
            else begin
                if (prev >= 0) begin
                    total++;
                    if (idx != (prev + 1) % DIGITS || (!first && run != RDIV)) begin
                        bad++;
                        $display("FAIL %s scan: digit%0d held %0d then digit%0d, required %0d then digit%0d",
                                 name, prev, run, idx, RDIV, (prev + 1) % DIGITS);
                    end
                    first = 1'b0;
                end
                prev = idx;
                run = 1;
            end
        end
    endtask

    task automatic do_load(input int v, input bit hx, input bit blz, input string name);
        int cnt = 0;
        int exp_busy = hx ? 1 : DATA_W + 1;
        @(negedge clk);
        bus.value = DATA_W'(v); bus.hex_mode = hx; bus.blank_lz = blz; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt != exp_busy) begin
            bad++;
            $display("FAIL %s busy_len: got %0d, required %0d", name, cnt, exp_busy);
        end
        compute_expected(v, hx, blz);
        total++;
        if (bus.overflow !== exp_ovf) begin
            bad++;
            $display("FAIL %s overflow: got %b, required %b", name, bus.overflow, exp_ovf);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.seg !== 7'h00 || bus.an !== 4'h0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: seg=%h an=%b busy=%b ovf=%b, required zero",
                     bus.seg, bus.an, bus.busy, bus.overflow);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_dark(40, "idle_dark");
        do_load(16'h1234, 1'b1, 1'b0, "pre_reset");
        check_display(6, "pre_reset");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.seg !== 7'h00 || bus.an !== 4'h0 || bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: seg=%h an=%b ovf=%b busy=%b, required zero",
                     bus.seg, bus.an, bus.overflow, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        check_dark(8, "post_reset_dark");
    endtask

    task automatic test_decimal();
        do_load(1234, 1'b0, 1'b0, "dec1234");
        check_display(40, "dec1234");
    endtask

    task automatic test_blanking();
        do_load(7, 1'b0, 1'b1, "blank7");
        check_display(20, "blank7");
        do_load(0, 1'b0, 1'b1, "blank0");
        check_display(20, "blank0");
    endtask

    task automatic test_hex();
        do_load(16'hBEEF, 1'b1, 1'b0, "hexBEEF");
        check_display(20, "hexBEEF");
    endtask

    task automatic test_overflow();
        do_load(12345, 1'b0, 1'b1, "ovf12345");
        check_display(20, "ovf12345");
        do_load(9999, 1'b0, 1'b1, "dec9999");
        check_display(20, "dec9999");
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        @(negedge clk);
        bus.value = 16'd42; bus.hex_mode = 1'b0; bus.blank_lz = 1'b0; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 3) begin
                bus.value = 16'd99; bus.load = 1'b1;
            end else bus.load = 1'b0;
            @(negedge clk);
        end
        bus.load = 1'b0;
        total++;
        if (cnt != DATA_W + 1) begin
            bad++;
            $display("FAIL b2b busy_len: got %0d, required %0d", cnt, DATA_W + 1);
        end
        compute_expected(42, 1'b0, 1'b0);
        check_display(20, "b2b_42");
        @(negedge clk);
        bus.value = 16'd123; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        check_display(6, "b2b_42_during_conv");
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.seg !== 7'h00 || bus.an !== 4'h0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_abort: seg=%h an=%b busy=%b, required zero", bus.seg, bus.an, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        check_dark(24, "b2b_dark");
        do_load(5, 1'b0, 1'b0, "b2b_5");
        check_display(20, "b2b_5");
    endtask

    task automatic test_random();
        int v;
        bit hx, blz;
        for (int it = 0; it < 10; it++) begin
            v   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
            hx  = 1'($urandom_range(0, 1));
            blz = 1'($urandom_range(0, 1));
            do_load(v, hx, blz, $sformatf("rand%0d", it));
            check_display(18, $sformatf("rand%0d", it));
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.value = '0; bus.hex_mode = 1'b0; bus.blank_lz = 1'b0;
        test_reset();
        test_decimal();
        test_blanking();
        test_hex();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
